// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    // Widest datapath the helpers cover; the unit uses up to 2*WIDTH bits of it.
    localparam int unsigned MAX_W = 128;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_CALC   = 2'b01,
        S_FINISH = 2'b10
    } state_e;

    // Two's-complement negate; callers truncate the result to their own width.
    function automatic logic [MAX_W-1:0] negate(input logic [MAX_W-1:0] x);
        return ~x + MAX_W'(1);
    endfunction

    function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] x, input logic neg);
        return neg ? negate(x) : x;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One bit per cycle: shift-add multiply, restoring divide.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] hilo_wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned W  = WIDTH;
    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [W-1:0]    opnd_q, opnd_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_q, neg_d, neg_r_q, neg_r_d, dbz_q, dbz_d;
    logic            busy_d, done_d, div_by_zero_d;
    logic [W-1:0]    hi_d, lo_d;

    // Operand conditioning at the start edge
    logic         in_div, in_signed, sign_a, sign_b;
    logic [W-1:0] mag_a, mag_b;

    assign in_div    = op[1];
    assign in_signed = ~op[0];
    assign sign_a    = in_signed & opA[W-1];
    assign sign_b    = in_signed & opB[W-1];
    assign mag_a     = W'(abs_val(MAX_W'(opA), sign_a));
    assign mag_b     = W'(abs_val(MAX_W'(opB), sign_b));

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    logic [W:0]   mul_sum, div_shift, div_diff;
    logic         div_ge;
    logic [W-1:0] div_rem;

    assign mul_sum   = {1'b0, acc_q[DW-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = {acc_q[DW-1:W], acc_q[W-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_ge    = ~div_diff[W];
    assign div_rem   = div_ge ? div_diff[W-1:0] : div_shift[W-1:0];

    logic          latched_div;
    logic [DW-1:0] prod_fix;
    logic [W-1:0]  quo_fix, rem_fix;

    assign latched_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
    assign prod_fix    = neg_q ? DW'(negate(MAX_W'(acc_q))) : acc_q;
    assign quo_fix     = neg_q ? W'(negate(MAX_W'(acc_q[W-1:0]))) : acc_q[W-1:0];
    assign rem_fix     = neg_r_q ? W'(negate(MAX_W'(acc_q[DW-1:W]))) : acc_q[DW-1:W];

    // Next-state and output logic
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        opnd_d        = opnd_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        neg_d         = neg_q;
        neg_r_d       = neg_r_q;
        dbz_d         = dbz_q;
        busy_d        = busy;
        done_d        = 1'b0;
        div_by_zero_d = 1'b0;
        hi_d          = hi;
        lo_d          = lo;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                // busy still high here means this is the done cycle: ignore requests
                if (!busy) begin
                    if (hi_we) hi_d = hilo_wdata;
                    if (lo_we) lo_d = hilo_wdata;
                    if (start) begin
                        op_d    = op_e'(op);
                        neg_d   = sign_a ^ sign_b;
                        neg_r_d = sign_a;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        dbz_d   = 1'b0;
                        state_d = S_CALC;
                        if (in_div) begin
                            opnd_d = mag_b;
                            acc_d  = {W'(0), mag_a};
                            if (opB == '0) begin
                                dbz_d   = 1'b1;
                                state_d = S_FINISH;
                            end
                        end else begin
                            opnd_d = mag_a;
                            acc_d  = {W'(0), mag_b};
                        end
                    end
                end
            end
            S_CALC: begin
                if (latched_div) acc_d = {div_rem, acc_q[W-2:0], div_ge};
                else             acc_d = {mul_sum, acc_q[W-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = S_FINISH;
            end
            S_FINISH: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                dbz_d   = 1'b0;
                if (dbz_q) begin
                    div_by_zero_d = 1'b1;
                end else if (latched_div) begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                end else begin
                    hi_d = prod_fix[DW-1:W];
                    lo_d = prod_fix[W-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= OP_MULT;
            opnd_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            neg_r_q     <= 1'b0;
            dbz_q       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            opnd_q      <= opnd_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            neg_r_q     <= neg_r_d;
            dbz_q       <= dbz_d;
            busy        <= busy_d;
            done        <= done_d;
            div_by_zero <= div_by_zero_d;
            hi          <= hi_d;
            lo          <= lo_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit (WIDTH=32): directed corner cases plus random ops
// checked against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;

    localparam int unsigned W = 32;

    logic          Clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  opA, opB;
    logic          hi_we, lo_we;
    logic [W-1:0]  hilo_wdata;
    logic          busy, done, div_by_zero;
    logic [W-1:0]  hi, lo;

    int            errors = 0;
    int            checks = 0;
    logic [31:0]   m_hi = '0;
    logic [31:0]   m_lo = '0;

    muldiv_unit #(.WIDTH(W)) dut (
        .Clk(Clk), .reset(reset), .start(start), .op(op), .opA(opA), .opB(opB),
        .hi_we(hi_we), .lo_we(lo_we), .hilo_wdata(hilo_wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Reference: full-width arithmetic, C-style truncating division
    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el, output logic edbz);
        longint      sa, sb;
        logic [63:0] p, q, r;
        edbz = 1'b0;
        eh   = m_hi;
        el   = m_lo;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        case (o)
            2'b00: begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; end
            2'b01: begin p = 64'(a) * 64'(b); eh = p[63:32]; el = p[31:0]; end
            2'b10: begin
                if (b == 32'd0) edbz = 1'b1;
                else begin q = 64'(sa / sb); r = 64'(sa % sb); el = q[31:0]; eh = r[31:0]; end
            end
            default: begin
                if (b == 32'd0) edbz = 1'b1;
                else begin el = a / b; eh = a % b; end
            end
        endcase
    endtask

    task automatic write_hilo(input logic wh, input logic wl, input logic [31:0] wd);
        @(negedge Clk);
        hi_we = wh; lo_we = wl; hilo_wdata = wd;
        if (wh) m_hi = wd;
        if (wl) m_lo = wd;
        @(posedge Clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit interfere,
                          input logic wh, input logic wl, input logic [31:0] wd);
        logic [31:0] eh, el;
        logic        edbz;
        int          lat, cyc;
        bit          seen;
        @(negedge Clk);
        start = 1'b1; op = o; opA = a; opB = b;
        hi_we = wh; lo_we = wl; hilo_wdata = wd;
        if (wh) m_hi = wd;
        if (wl) m_lo = wd;
        model(o, a, b, eh, el, edbz);
        @(posedge Clk); #1;
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        lat  = edbz ? 1 : W + 1;
        seen = 1'b0;
        cyc  = 0;
        for (int c = 1; c <= W + 8; c++) begin
            @(posedge Clk); #1;
            if (interfere && c == 6) begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; op = o; opA = a; opB = b;
            end
            if (done) begin cyc = c; seen = 1'b1; break; end
            chk({tag, " busy_mid"}, 64'(busy), 64'd1);
            chk({tag, " dbz_low"}, 64'(div_by_zero), 64'd0);
            if (interfere && c == 5) begin
                start = 1'b1; op = ~o; opA = $urandom; opB = 32'd0;
                hi_we = 1'b1; lo_we = 1'b1; hilo_wdata = 32'hDEADBEEF;
            end
        end
        chk({tag, " done_seen"}, 64'(seen), 64'd1);
        chk({tag, " latency"}, 64'(cyc), 64'(lat));
        chk({tag, " busy_done"}, 64'(busy), 64'd1);
        chk({tag, " dbz"}, 64'(div_by_zero), 64'(edbz));
        chk({tag, " hi"}, 64'(hi), 64'(eh));
        chk({tag, " lo"}, 64'(lo), 64'(el));
        m_hi = eh;
        m_lo = el;
        @(posedge Clk); #1;
        chk({tag, " done_pulse"}, 64'(done), 64'd0);
        chk({tag, " busy_after"}, 64'(busy), 64'd0);
        chk({tag, " dbz_after"}, 64'(div_by_zero), 64'd0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        bit          seen;

        reset = 1'b1; start = 1'b0; op = 2'b00; opA = '0; opB = '0;
        hi_we = 1'b0; lo_we = 1'b0; hilo_wdata = '0;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset dbz", 64'(div_by_zero), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        @(negedge Clk);
        reset = 1'b0;

        run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, '0);
        chk("multu_max hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFE);
        chk("multu_max lo_const", 64'(lo), 64'h0000_0000_0000_0001);

        run_op("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b0, 1'b0, '0);
        chk("mult_neg hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        chk("mult_neg lo_const", 64'(lo), 64'h0000_0000_FFFF_FFEB);

        run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 1'b0, '0);
        chk("div_neg lo_const", 64'(lo), 64'h0000_0000_FFFF_FFFD);
        chk("div_neg hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFF);

        write_hilo(1'b1, 1'b0, 32'h12345678);
        write_hilo(1'b0, 1'b1, 32'h9ABCDEF0);
        chk("mthi", 64'(hi), 64'h0000_0000_1234_5678);
        chk("mtlo", 64'(lo), 64'h0000_0000_9ABC_DEF0);
        run_op("divu_zero", 2'b11, 32'd100, 32'd0, 1'b0, 1'b0, 1'b0, '0);
        chk("divu_zero hi_kept", 64'(hi), 64'h0000_0000_1234_5678);
        chk("divu_zero lo_kept", 64'(lo), 64'h0000_0000_9ABC_DEF0);

        run_op("div_minneg", 2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, '0);
        chk("div_minneg lo_const", 64'(lo), 64'h0000_0000_8000_0000);
        chk("div_minneg hi_const", 64'(hi), 64'd0);

        run_op("mult_interfere", 2'b00, 32'h12345678, 32'hFFFF9ABC, 1'b1, 1'b0, 1'b0, '0);
        run_op("divu_interfere", 2'b11, 32'hF0F0F0F0, 32'd12345, 1'b1, 1'b0, 1'b0, '0);

        run_op("coinc_div0", 2'b10, 32'd55, 32'd0, 1'b0, 1'b1, 1'b0, 32'hCAFEF00D);
        chk("coinc_div0 hi_written", 64'(hi), 64'h0000_0000_CAFE_F00D);
        run_op("coinc_multu", 2'b01, 32'd3, 32'd5, 1'b0, 1'b1, 1'b1, 32'h55AA55AA);
        chk("coinc_multu lo_over", 64'(lo), 64'd15);

        // Abort a MULT partway through with an asynchronous reset
        @(negedge Clk);
        start = 1'b1; op = 2'b00; opA = 32'hFFFFFFFD; opB = 32'd7;
        @(posedge Clk); #1;
        start = 1'b0;
        repeat (9) @(posedge Clk);
        #2 reset = 1'b1;
        #1;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        chk("abort hi", 64'(hi), 64'd0);
        chk("abort lo", 64'(lo), 64'd0);
        @(negedge Clk);
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge Clk); #1;
            if (done) seen = 1'b1;
        end
        chk("abort no_done", 64'(seen), 64'd0);
        run_op("divu_after_reset", 2'b11, 32'd9, 32'd4, 1'b0, 1'b0, 1'b0, '0);
        chk("divu_after_reset lo_const", 64'(lo), 64'd2);
        chk("divu_after_reset hi_const", 64'(hi), 64'd1);

        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = 32'($urandom_range(1, 16));
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d", i), ro, ra, rb, 1'b0,
                   1'($urandom_range(0, 1)), 1'b0, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
